// File: rtl/axis_buffer_pkg.sv
// Shared types and elaboration helpers for the URAM capture-buffer read engine.
package axis_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int read_latency(input int nbpipe);
        return nbpipe + 2;
    endfunction

    // The skid FIFO must absorb every in-flight read plus one pending pop.
    function automatic bit fifo_depth_ok(input int depth, input int nbpipe);
        return (depth > 0) && ((depth & (depth - 1)) == 0) &&
               (depth >= read_latency(nbpipe) + 1);
    endfunction

endpackage

// File: rtl/axis_buffer_rd_fifo.sv
// Synchronous show-ahead FIFO: pop_data always presents the head entry.
module axis_buffer_rd_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is reset so the stream data reads as zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/axis_buffer_uram_rd.sv
// URAM port-B read engine streaming a burst onto AXI4-Stream under credit control.
// Optional end-of-burst marker enabled by defining AXIS_BUFFER_RD_TLAST_EN.
module axis_buffer_uram_rd
    import axis_buffer_pkg::*;
#(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 72,
    parameter int NBPIPE     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   start_len,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_ce,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
`ifdef AXIS_BUFFER_RD_TLAST_EN
    ,
    output logic              m_axis_tlast
`endif
);

    localparam int L  = read_latency(NBPIPE);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef AXIS_BUFFER_RD_TLAST_EN
    localparam int FW = DWIDTH + 1;
`else
    localparam int FW = DWIDTH;
`endif

    if (!fifo_depth_ok(FIFO_DEPTH, NBPIPE)) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two and at least the read latency + 1");
    end

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH:0]   remaining;
    logic [L-1:0]      vld_sr;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic              accept;
    logic              credit_ok;
    logic              issue;
    logic              final_issue;

    assign accept      = (state == IDLE) && start && (start_len != '0);
    assign credit_ok   = !fifo_full &&
                         (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
    assign issue       = (state == ISSUE) && credit_ok;
    assign final_issue = issue && (remaining == (AWIDTH + 1)'(1));
    assign fifo_push   = vld_sr[L-1];
    assign fifo_pop    = !fifo_empty && m_axis_tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN exits on the cycle the last word leaves so busy drops right after it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (final_issue) state_next = DRAIN;
            DRAIN:   if ((inflight == '0) && (fifo_count == CW'(fifo_pop))) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr      <= '0;
            remaining <= '0;
            vld_sr    <= '0;
            inflight  <= '0;
        end else begin
            if (accept) begin
                addr      <= start_addr;
                remaining <= start_len;
            end else if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            vld_sr <= {vld_sr[L-2:0], issue};
            case ({issue, fifo_push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef AXIS_BUFFER_RD_TLAST_EN
    // Last-word flag travels alongside the read through the URAM latency.
    logic [L-1:0] last_sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_sr <= '0;
        end else begin
            last_sr <= {last_sr[L-2:0], final_issue};
        end
    end

    assign fifo_din      = {last_sr[L-1], mem_dout};
    assign m_axis_tdata  = fifo_dout[DWIDTH-1:0];
    assign m_axis_tlast  = fifo_dout[DWIDTH];
`else
    assign fifo_din      = mem_dout;
    assign m_axis_tdata  = fifo_dout;
`endif

    axis_buffer_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy          = (state != IDLE);
    assign mem_en        = issue;
    assign mem_we        = 1'b0;
    assign mem_ce        = 1'b1;
    assign mem_addr      = addr;
    assign m_axis_tvalid = !fifo_empty;

endmodule

// File: doc/axis_buffer_uram_rd.md
# axis_buffer_uram_rd

Read-out engine for the URAM capture buffer. A start command gives a base address and a word count. The block issues reads on the dual-port URAM's read port (port B) and absorbs the fixed URAM read latency. It then streams the words out on an AXI4-Stream master. A small skid FIFO and credit counting keep full throughput under arbitrary `tready` backpressure without ever dropping a word.

## Interface
Parameters:
- `AWIDTH` = 12: URAM address width; must match the URAM instance.
- `DWIDTH` = 72: data width; must match the URAM instance.
- `NBPIPE` = 3: URAM output pipeline registers. Read latency is L = NBPIPE+2.
- `FIFO_DEPTH` = 8: skid FIFO depth. Must be a power of two and ≥ L+1.

Ports:
- `clk` in 1: single clock for the whole block.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command strobe. Ignored while `busy`=1.
- `start_addr` in AWIDTH: first word address.
- `start_len` in AWIDTH+1: number of words, 1..2^AWIDTH. A value of 0 is ignored.
- `busy` out 1: high from the accepted `start` until the last word has been accepted downstream.
- `mem_en` out 1: URAM port-B enable. High for exactly one cycle per issued read.
- `mem_we` out 1: tied 0.
- `mem_ce` out 1: tied 1.
- `mem_addr` out AWIDTH: URAM port-B address.
- `mem_dout` in DWIDTH: URAM port-B output data.
- `m_axis_tdata` out DWIDTH: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: end-of-burst marker. Present only with the macro described under Configuration.

## Operation
- State machine states: IDLE, ISSUE, DRAIN.
- **IDLE:**
  - `start`=1 with `start_len`≠0 loads the address counter from `start_addr`.
  - It loads the remaining-issue counter from `start_len`.
  - It then moves to ISSUE.
- **ISSUE:** each cycle where the credit rule holds:
  - `mem_en`=1 and `mem_addr` = address counter;
  - the address counter increments modulo 2^AWIDTH (wraps from 2^AWIDTH−1 to 0);
  - the remaining-issue counter decrements;
  - when the final read is issued, the state moves to DRAIN.
- **Credit rule:** issue only when in-flight + FIFO occupancy < FIFO_DEPTH.
  - In-flight = reads issued but not yet returned, range 0..L.
- **DRAIN:** wait until in-flight = 0 and the FIFO is empty, then return to IDLE. `busy` falls on the cycle IDLE is entered.
- **Returned-data tracking:** a valid shift register of length L.
  - Bit 0 loads `mem_en`.
  - Its output pushes `mem_dout` into the FIFO.
  - The URAM's own enable pipeline is never trusted. After an `rstn` assertion, data still draining from the URAM is discarded because the shift register was cleared.
- **FIFO:**
  - Push and pop in the same cycle is legal.
  - Push into a full FIFO cannot occur (guaranteed by the credit rule); the bench asserts this.
  - `m_axis_tvalid` = FIFO not empty. A pop happens when `tvalid` & `tready`.
- **`start` while busy:** dropped. No queueing.

## Timing
- **Reset values** (`rstn`=0):
  - `busy`=0, `mem_en`=0, `mem_addr`=0;
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0;
  - state = IDLE, all counters 0, shift register cleared, FIFO empty.
  - Reset mid-burst aborts with no further output.
- `start` at cycle 0 gives the first `mem_en` at cycle 1 and `busy`=1 from cycle 1.
- First `m_axis_tvalid` appears at cycle 1+L+1. With L=5 (NBPIPE=3) that is cycle 7.
  - One cycle is the FIFO write; the output is registered from the FIFO.
- With `tready` held at 1, `mem_en` stays high for `start_len` consecutive cycles and output is gap-free.
- With `tready`=0, issue stops once occupancy + in-flight reaches FIFO_DEPTH. Issue resumes one cycle after a pop.

## Configuration
- Macro: `AXIS_BUFFER_RD_TLAST_EN`.
- **Defined:**
  - the `m_axis_tlast` port exists;
  - each FIFO entry carries one extra bit, set on the word issued with remaining-issue = 1;
  - `tlast`=1 exactly on the last word of each burst.
- **Undefined:**
  - no `tlast` port;
  - FIFO width = DWIDTH;
  - no tlast logic.

## Structure
- **Package `axis_buffer_pkg`:**
  - state enum (IDLE/ISSUE/DRAIN);
  - localparam function for the read latency, NBPIPE+2;
  - the FIFO_DEPTH legality check, used in an elaboration-time assertion.
- **Sub-module `axis_buffer_rd_fifo`:**
  - synchronous show-ahead FIFO;
  - parameters WIDTH and DEPTH;
  - outputs push/pop, full, empty and count;
  - async active-low reset.

## Test plan
- Burst with `start_addr`=0x010, `start_len`=4, `tready`=1 → `mem_addr` 0x010..0x013 on cycles 1–4; data out on cycles 7–10; `tlast` only on word 4; `busy` low on cycle 11.
- Wrap with `start_addr`=0xFFE, `start_len`=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
- Backpressure with `start_len`=32 and `tready` toggling 1-0 → all 32 words delivered in order; FIFO never overflows; in-flight + occupancy ≤ 8 on every cycle.
- Full depth with `start_len`=4096, `tready`=1 → exactly 4096 `mem_en` pulses and 4096 beats. `start_len`=0 → no activity and `busy` stays 0.
- `start` pulsed at cycle 3 of a running burst → ignored; beat count equals the first `start_len` only.
- `rstn` dropped at cycle 4 of a 16-word burst, then released and a new burst of 2 issued → exactly 2 beats out; no stale words.
